// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port, the load/store port and the
// shared memory port of the two-requester memory arbiter.
// slave  - the arbiter's view (requests in, acks/memory access out)
// master - the view of the surroundings (requesters and memory model)
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction-fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;

    // Load/store requester
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    // Shared single-ported memory
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  if_req, if_addr,
        output if_ack, if_rdata, if_err,
        input  d_req, d_we, d_addr, d_wdata,
        output d_ack, d_rdata, d_err,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output if_req, if_addr,
        input  if_ack, if_rdata, if_err,
        output d_req, d_we, d_addr, d_wdata,
        input  d_ack, d_rdata, d_err,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the instruction-fetch
// and load/store paths. Ties are broken round-robin; each transaction runs
// IDLE -> BUSY (mem_req held until mem_ready) -> RESP (one-cycle ack).
// All outputs are registered; rst is asynchronous and active-low.
// Optional build macro MEMARB_TIMEOUT_EN: abort a BUSY wait after TIMEOUT
// cycles and return the ack with err set. Without it, BUSY waits forever
// and if_err / d_err are constant 0.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } stateType;

    // The wait counter must be able to reach TIMEOUT-1 from zero.
    generate
        if (TIMEOUT < 2) begin : gTimeoutTooSmall
            $error("mem_arbiter: TIMEOUT must be >= 2");
        end
    endgenerate

    stateType          stateReg;
    logic              lastGrantD;   // 1 = data was granted most recently
    logic              grantD;       // requester owning the current transaction
    logic              memReqReg;
    logic              memWeReg;
    logic [ADDR_W-1:0] memAddrReg;
    logic [DATA_W-1:0] memWdataReg;
    logic              ifAckReg;
    logic              dAckReg;
    logic [DATA_W-1:0] ifRdataReg;
    logic [DATA_W-1:0] dRdataReg;
    logic              busyReg;

`ifdef MEMARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    logic [CNT_W-1:0]  waitCnt;
    logic              ifErrReg;
    logic              dErrReg;
`endif

    // Data wins when it is the only requester, or on a tie when fetch went last.
    logic pickD;
    assign pickD = bus.d_req && (!bus.if_req || !lastGrantD);

    // Arbitration FSM: grant, hold the memory access, then pulse the ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg    <= IDLE;
            lastGrantD  <= 1'b0;
            grantD      <= 1'b0;
            memReqReg   <= 1'b0;
            memWeReg    <= 1'b0;
            memAddrReg  <= '0;
            memWdataReg <= '0;
            ifAckReg    <= 1'b0;
            dAckReg     <= 1'b0;
            ifRdataReg  <= '0;
            dRdataReg   <= '0;
            busyReg     <= 1'b0;
`ifdef MEMARB_TIMEOUT_EN
            waitCnt     <= '0;
            ifErrReg    <= 1'b0;
            dErrReg     <= 1'b0;
`endif
        end else begin
            case (stateReg)
                IDLE: begin
                    if (bus.if_req || bus.d_req) begin
                        grantD      <= pickD;
                        lastGrantD  <= pickD;
                        memReqReg   <= 1'b1;
                        memWeReg    <= pickD ? bus.d_we : 1'b0;
                        memAddrReg  <= pickD ? bus.d_addr : bus.if_addr;
                        memWdataReg <= pickD ? bus.d_wdata : '0;
                        busyReg     <= 1'b1;
                        stateReg    <= BUSY;
`ifdef MEMARB_TIMEOUT_EN
                        waitCnt     <= '0;
`endif
                    end
                end

                BUSY: begin
                    if (bus.mem_ready) begin
                        memReqReg <= 1'b0;
                        if (grantD) begin
                            dRdataReg <= bus.mem_rdata;
                            dAckReg   <= 1'b1;
                        end else begin
                            ifRdataReg <= bus.mem_rdata;
                            ifAckReg   <= 1'b1;
                        end
                        stateReg <= RESP;
                    end
`ifdef MEMARB_TIMEOUT_EN
                    else if (waitCnt == CNT_W'(TIMEOUT - 1)) begin
                        // Memory never answered: complete with err and zero data.
                        memReqReg <= 1'b0;
                        if (grantD) begin
                            dRdataReg <= '0;
                            dAckReg   <= 1'b1;
                            dErrReg   <= 1'b1;
                        end else begin
                            ifRdataReg <= '0;
                            ifAckReg   <= 1'b1;
                            ifErrReg   <= 1'b1;
                        end
                        stateReg <= RESP;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
`endif
                end

                RESP: begin
                    // Ack lasts one cycle; requests are not looked at here.
                    ifAckReg <= 1'b0;
                    dAckReg  <= 1'b0;
                    memWeReg <= 1'b0;
                    busyReg  <= 1'b0;
                    stateReg <= IDLE;
`ifdef MEMARB_TIMEOUT_EN
                    ifErrReg <= 1'b0;
                    dErrReg  <= 1'b0;
`endif
                end

                default: begin
                    stateReg <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = memReqReg;
    assign bus.mem_we    = memWeReg;
    assign bus.mem_addr  = memAddrReg;
    assign bus.mem_wdata = memWdataReg;
    assign bus.if_ack    = ifAckReg;
    assign bus.d_ack     = dAckReg;
    assign bus.if_rdata  = ifRdataReg;
    assign bus.d_rdata   = dRdataReg;
    assign busy          = busyReg;

`ifdef MEMARB_TIMEOUT_EN
    assign bus.if_err = ifErrReg;
    assign bus.d_err  = dErrReg;
`else
    assign bus.if_err = 1'b0;
    assign bus.d_err  = 1'b0;
`endif

endmodule
